// File: rtl/multi_switch_debouncer_if.sv
// Switch-bank interface: raw switch inputs in, debounced levels and event strobes out.
// master drives the raw switches; slave is the debouncer side.
interface multi_switch_debouncer_if #(
   parameter int unsigned NUM_CH = 4
);
   logic [NUM_CH-1:0] sw_in;
   logic [NUM_CH-1:0] sw_out;
   logic [NUM_CH-1:0] sw_rise;
   logic [NUM_CH-1:0] sw_fall;
   logic [NUM_CH-1:0] sw_long;
   logic              any_change;

   modport master (
      output sw_in,
      input  sw_out, sw_rise, sw_fall, sw_long, any_change
   );

   modport slave (
      input  sw_in,
      output sw_out, sw_rise, sw_fall, sw_long, any_change
   );
endinterface

// File: rtl/multi_switch_debouncer.sv
// N-channel switch debouncer: shared tick prescaler, per-channel synchronisers and debounce FSMs.
// Optional feature macro LONG_PRESS_EN adds a per-channel long-press strobe on sw_long.
module multi_switch_debouncer #(
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned TICK_DIV       = 50000,
   parameter int unsigned DEBOUNCE_TICKS = 20,
   parameter int unsigned LONG_TICKS     = 1000,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned ACTIVE_LOW     = 0
) (
   input logic                      clk,
   input logic                      rst,
   multi_switch_debouncer_if.slave  bus
);
   localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned CNT_W  = $clog2(DEBOUNCE_TICKS + 1);
   localparam int unsigned HOLD_W = $clog2(LONG_TICKS + 1);

   typedef enum logic {ST_STABLE, ST_PENDING} state_e;

   logic [PRE_W-1:0]                   pre_q, pre_d;
   logic                               tick_c;
   logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
   logic [NUM_CH-1:0]                  s_c;
   state_e                             state_q [NUM_CH];
   state_e                             state_d [NUM_CH];
   logic [CNT_W-1:0]                   cnt_q [NUM_CH];
   logic [CNT_W-1:0]                   cnt_d [NUM_CH];
   logic [NUM_CH-1:0]                  out_q, out_d;
   logic [NUM_CH-1:0]                  rise_q, rise_d;
   logic [NUM_CH-1:0]                  fall_q, fall_d;
   logic                               any_q, any_d;

   // Shared prescaler; with TICK_DIV=1 the tick is permanently high.
   always_comb begin
      pre_d  = pre_q;
      tick_c = 1'b1;
      if (TICK_DIV > 1) begin
         tick_c = (pre_q == PRE_W'(TICK_DIV - 1));
         pre_d  = tick_c ? '0 : pre_q + PRE_W'(1);
      end
   end

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = (ACTIVE_LOW != 0) ? ~bus.sw_in : bus.sw_in;
      for (int unsigned st = 1; st < SYNC_STAGES; st++) begin
         sync_d[st] = sync_q[st-1];
      end
   end

   assign s_c = sync_q[SYNC_STAGES-1];

   // Per-channel debounce FSM; a commit is the only way sw_out can change.
   always_comb begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         out_d[i]   = out_q[i];
         rise_d[i]  = 1'b0;
         fall_d[i]  = 1'b0;
         case (state_q[i])
            ST_STABLE: begin
               if (s_c[i] != out_q[i]) begin
                  state_d[i] = ST_PENDING;
                  cnt_d[i]   = '0;
               end
            end
            ST_PENDING: begin
               if (s_c[i] == out_q[i]) begin
                  state_d[i] = ST_STABLE;
               end else if (tick_c) begin
                  if (cnt_q[i] == CNT_W'(DEBOUNCE_TICKS - 1)) begin
                     out_d[i]   = s_c[i];
                     rise_d[i]  = s_c[i];
                     fall_d[i]  = ~s_c[i];
                     state_d[i] = ST_STABLE;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
                  end
               end
            end
            default: state_d[i] = ST_STABLE;
         endcase
      end
      any_d = |(rise_d | fall_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q  <= '0;
         sync_q <= '0;
         out_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
         any_q  <= 1'b0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_q[i] <= ST_STABLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         pre_q  <= pre_d;
         sync_q <= sync_d;
         out_q  <= out_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         any_q  <= any_d;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   assign bus.sw_out     = out_q;
   assign bus.sw_rise    = rise_q;
   assign bus.sw_fall    = fall_q;
   assign bus.any_change = any_q;

`ifdef LONG_PRESS_EN
   logic [HOLD_W-1:0] hold_q [NUM_CH];
   logic [HOLD_W-1:0] hold_d [NUM_CH];
   logic [NUM_CH-1:0] long_q, long_d;

   // Hold counter saturates at LONG_TICKS so the strobe fires once per press.
   always_comb begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         hold_d[i] = hold_q[i];
         long_d[i] = 1'b0;
         if (rise_d[i] || fall_d[i] || !out_q[i]) begin
            hold_d[i] = '0;
         end else if (tick_c && (hold_q[i] != HOLD_W'(LONG_TICKS))) begin
            hold_d[i] = hold_q[i] + HOLD_W'(1);
            long_d[i] = (hold_q[i] == HOLD_W'(LONG_TICKS - 1));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         long_q <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            hold_q[i] <= '0;
         end
      end else begin
         long_q <= long_d;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            hold_q[i] <= hold_d[i];
         end
      end
   end

   assign bus.sw_long = long_q;
`else
   assign bus.sw_long = '0;
`endif

endmodule

// File: doc/multi_switch_debouncer.md
Name: multi_switch_debouncer

Overview:
Parametrised N-channel switch debouncer with a shared tick prescaler, per-channel metastability synchronisers and per-channel debounce FSMs. It produces debounced levels, one-cycle rise/fall strobes and an optional long-press strobe. It sits between raw board I/O (switches, buttons) and control logic, and replaces single-channel debouncing with one block per switch bank.

Parameters:
NUM_CH, 4, number of independent switch channels (>=1)
TICK_DIV, 50000, clk cycles per debounce tick (1 ms at 50 MHz); 1 = tick every cycle
DEBOUNCE_TICKS, 20, ticks input must stay changed before commit (>=1)
LONG_TICKS, 1000, ticks debounced level must stay 1 before long-press strobe (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
ACTIVE_LOW, 0, 1 = raw input inverted before synchroniser (pressed = 0 on pin)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
sw_in  input  NUM_CH  raw asynchronous switch inputs
sw_out  output  NUM_CH  debounced level per channel (1 = pressed)
sw_rise  output  NUM_CH  one-cycle strobe when sw_out bit commits 0->1
sw_fall  output  NUM_CH  one-cycle strobe when sw_out bit commits 1->0
sw_long  output  NUM_CH  one-cycle strobe on long press (0 when LONG_PRESS_EN undefined)
any_change  output  1  OR of all sw_rise|sw_fall bits, same cycle

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All flops sample rst on the clk rising edge only.
- Reset values: sw_out=0, sw_rise=0, sw_fall=0, sw_long=0, any_change=0. Synchroniser chains, prescaler, debounce counters and hold counters are 0. All FSMs are in STABLE.
- Polarity: when ACTIVE_LOW=1, sw_in is inverted ahead of stage 1. All later logic is active-high.
- Prescaler: free-running 0..TICK_DIV-1 counter. tick=1 for one cycle when the count equals TICK_DIV-1, then wraps to 0. When TICK_DIV=1, tick is held 1. Shared by all channels.
- s[i] = output of the last synchroniser stage.
- Per-channel FSM, two states:
  - STABLE: if s!=sw_out, go to PENDING with cnt<=0. Otherwise remain.
  - PENDING: if s==sw_out, go to STABLE (glitch rejected, no strobe). Else on tick: if cnt==DEBOUNCE_TICKS-1, commit (sw_out<=s, strobe sw_rise or sw_fall, go to STABLE); otherwise cnt<=cnt+1. Without tick, hold.
- cnt width is $clog2(DEBOUNCE_TICKS+1). cnt never exceeds DEBOUNCE_TICKS-1.
- Latency with TICK_DIV=1: a sw_in value sampled at edge k appears on sw_out after edge k+SYNC_STAGES+DEBOUNCE_TICKS.
- Rejection with TICK_DIV=1: a raw pulse of <=DEBOUNCE_TICKS cycles is rejected; a pulse of >=DEBOUNCE_TICKS+1 cycles is committed.
- Strobes are registered and asserted in the same cycle that sw_out changes. They are high for exactly one cycle.
- Channels are fully independent. Any number of sw_rise/sw_fall bits may assert in the same cycle. any_change asserts once for that cycle.
- Reset mid-PENDING discards the pending change and emits no strobe. After rst falls, a held-high input is debounced from scratch with full latency.
- sw_out only changes through a commit; no path bypasses debouncing.

Optional Feature:
- Macro LONG_PRESS_EN.
- Defined: each channel has a hold counter of width $clog2(LONG_TICKS+1).
  - Cleared on every commit and whenever sw_out=0.
  - Increments on tick while sw_out=1.
  - On the tick where it equals LONG_TICKS-1, sw_long pulses for one cycle and the counter saturates at LONG_TICKS. There is no repeat until release and re-press.
  - With TICK_DIV=1, sw_long pulses exactly LONG_TICKS cycles after sw_rise.
- Undefined: no hold counters are synthesised and sw_long is tied to 0.

Test Plan:
- Common setup: NUM_CH=4, TICK_DIV=1, DEBOUNCE_TICKS=3, SYNC_STAGES=2, LONG_TICKS=8.
- Clean press: sw_in[0] goes 0->1 before edge k and is held -> sw_out[0]=1 and sw_rise[0]=1 after edge k+5, with sw_rise[0] and any_change high for 1 cycle. Release gives the mirror sw_fall[0] 5 cycles after the release is sampled.
- Glitch rejection: sw_in[1] high for 3 cycles then low -> sw_out[1] stays 0 and no strobes. The same pulse held 4 cycles -> sw_rise[1] fires.
- Bounce: sw_in[2] toggles 1,0,1,0,1 on consecutive cycles then holds 1 -> exactly one sw_rise[2], 5 cycles after the final 0->1 is sampled.
- Simultaneous and independent: sw_in=4'b1010 applied in one cycle -> sw_rise=4'b1010 in one cycle and any_change=1 for 1 cycle. Channels 0 and 2 show no activity.
- Reset mid-operation: assert rst for 1 cycle while ch0 is PENDING (cnt=1) -> all outputs 0 and no strobe. sw_in[0] still high -> sw_rise[0] occurs 5 cycles after rst deasserts.
- Long press (LONG_PRESS_EN defined): hold sw_in[3]=1 -> sw_long[3] pulses once, 8 cycles after sw_rise[3], and does not repeat while held. Release, re-press -> pulses again. With the macro undefined -> sw_long=0 throughout.
